// File: rtl/parallel_to_serial_if.sv
// Word-in / byte-out handshake bundle for parallel_to_serial.
// The slave modport is the serializer's view of the bus; the master modport is its environment's view.
interface parallel_to_serial_if #(
  parameter int unsigned N = 16
);
  logic [N-1:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         word_done;

  modport slave (
    input  in_word,
    input  in_valid,
    input  tx_ready,
    output in_ready,
    output tx_byte,
    output tx_valid,
    output busy,
    output word_done
  );

  modport master (
    output in_word,
    output in_valid,
    output tx_ready,
    input  in_ready,
    input  tx_byte,
    input  tx_valid,
    input  busy,
    input  word_done
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Serializes one N-bit word into N/8 bytes, most-significant byte first, over a valid/ready handshake.
// Optional trailing XOR checksum byte: define PARALLEL_TO_SERIAL_CHECKSUM_EN.
module parallel_to_serial #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 3
) (
  input logic                 iCE_CLK,
  input logic                 rst_n,
  parallel_to_serial_if.slave bus
);

  localparam int unsigned NumBytes = N / 8;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NumBytes - 1);
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(NumBytes);
`else
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(NumBytes - 1);
`endif

`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSend, StCsum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSend} state_e;
`endif

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           done_q, done_d;
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif

  logic           in_ready;
  logic           tx_valid;
  logic [7:0]     tx_byte;
  logic           busy;

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    busy     = 1'b1;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) begin
          shift_d = bus.in_word;
          cnt_d   = '0;
          state_d = StSend;
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      StSend: begin
        tx_valid = 1'b1;
        tx_byte  = shift_q[N-1 -: 8];
        if (bus.tx_ready) begin
          shift_d = {shift_q[N-9:0], 8'h00};
`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[N-1 -: 8];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StCsum;
          end
`else
          if (cnt_q == LastIdx) begin
            // Clear rather than increment so the count stays within 0..N/8-1.
            cnt_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
`endif
        end
      end

`ifdef PARALLEL_TO_SERIAL_CHECKSUM_EN
      StCsum: begin
        tx_valid = 1'b1;
        tx_byte  = csum_q;
        if (bus.tx_ready) begin
          cnt_d   = '0;
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_byte   = tx_byte;
  assign bus.busy      = busy;
  assign bus.word_done = done_q;

`ifndef SYNTHESIS
  // A presented byte must hold until it is taken.
  a_hold_under_backpressure : assert property (@(posedge iCE_CLK) disable iff (!rst_n)
    (tx_valid && !bus.tx_ready) |=> (tx_valid && $stable(tx_byte)));

  a_count_bounded : assert property (@(posedge iCE_CLK) disable iff (!rst_n)
    cnt_q <= CntMax);

  a_done_single_cycle : assert property (@(posedge iCE_CLK) disable iff (!rst_n)
    done_q |=> !done_q);
`endif

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Downstream neighbour of the UART receive-side word assembler.
- Takes one N-bit word from the crypto datapath (e.g. an RSA result) and emits it as N/8 bytes, most-significant byte first, to the UART transmitter over a valid/ready byte handshake.
- MSB-first order mirrors the assembler, which shifts each new byte in at the LSB end; a word sent out and looped back reassembles unchanged.

Parameters:
- N, 16, word width in bits; multiple of 8, N >= 16.
- CNT_W, 3, byte-counter width; must satisfy 2^CNT_W > N/8 (+1 when checksum compiled in).

Ports:
- iCE_CLK  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_word  input  N  word to transmit; sampled only on the accept cycle.
- in_valid  input  1  in_word is valid.
- in_ready  output  1  block can accept a word (high only in IDLE).
- tx_byte  output  8  current byte to the UART transmitter.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  UART transmitter accepts tx_byte this cycle.
- busy  output  1  a word is in flight (state != IDLE).
- word_done  output  1  one-cycle pulse after the final byte is accepted.

Behaviour:
- Reset (async assert, sync release): state=IDLE, shift register=0, byte count=0, tx_byte=8'h00, tx_valid=0, in_ready=1, busy=0, word_done=0.
- Word accept: in IDLE, in_valid && in_ready on a rising edge. Effects:
  - in_word is loaded into the shift register.
  - count is cleared to 0.
  - state moves to SEND.
- SEND state:
  - Outputs: tx_valid=1, tx_byte=shift_reg[N-1:N-8], in_ready=0, busy=1.
  - First byte is presented on the cycle after the accept (latency 1).
- Byte transfer: occurs on a cycle where tx_valid && tx_ready. On transfer, the shift register shifts left by 8 (zero fill) and count increments.
  - If count was N/8-1, state moves to IDLE and word_done pulses high for exactly one cycle (the first cycle back in IDLE).
  - Otherwise state stays in SEND and the next byte appears the following cycle.
- Backpressure: while tx_ready=0, tx_valid stays high and tx_byte stays stable. tx_valid never drops before a transfer.
- Back-to-back bytes: with tx_ready held high, one byte transfers per cycle, so a word takes N/8 cycles in SEND.
- Back-to-back words: the next word can be accepted in the IDLE cycle that carries word_done. Minimum gap between the last byte of one word and the first byte of the next is 1 idle cycle.
- Input held off: in_valid while busy is ignored; in_word is not sampled. The upstream must hold in_valid until in_ready.
- Counter wrap: count never exceeds N/8-1 (N/8 with checksum); it returns to 0 on every accept.
- Reset mid-word: the word is abandoned, all outputs return to reset values immediately, and no word_done is produced.
- Simultaneous reset and tx_ready: reset wins; no transfer is counted.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes is accumulated (cleared to 8'h00 on accept, updated on each data-byte transfer).
  - After the last data byte transfers, state moves to CSUM: tx_valid=1, tx_byte = XOR of all N/8 bytes.
  - The checksum byte uses the same backpressure rules as data bytes.
  - word_done pulses after the checksum byte transfers. A word takes N/8+1 transfers.
- Undefined: no CSUM state and no accumulator logic; exactly N/8 bytes per word.

Test Plan:
- N=16: reset, then in_word=16'hA55A with in_valid for 1 cycle and tx_ready=1 -> tx_byte A5 then 5A on consecutive cycles; word_done high on the next cycle; in_ready low for exactly 2 cycles.
- Backpressure, N=16, in_word=16'h1234: tx_ready=0 for 5 cycles, then 1 -> tx_valid=1 with tx_byte=12 stable for all 5 cycles; then 12, 34 transfer; word_done pulses once.
- N=32, in_word=32'hDEADBEEF, tx_ready toggling 1/0 -> byte order DE, AD, BE, EF; exactly 4 transfers.
- Words 16'hA55A and 16'h0F0F offered back-to-back, in_valid held high -> A5, 5A, (1 idle cycle), 0F, 0F; the second word is accepted on the word_done cycle.
- rst_n pulsed low after the first byte of 16'hBEEF -> tx_valid=0, busy=0, no word_done; the next word 16'h0102 emits 01, 02 correctly.
- With PARALLEL_TO_SERIAL_CHECKSUM_EN, N=16, in_word=16'hA55A -> A5, 5A, FF, then word_done; with 16'h1234 -> 12, 34, 26.
